keynsham_bus_initiator: RTL and testbench
=========================================

# keynsham_bus_initiator

Single-outstanding bus initiator for the keynsham peripheral bus: it accepts one read or write command at a time from a local client (debug controller, DMA sequencer), drives the peripheral bus access/ack handshake, and returns read data or an error to the client. It is the initiator counterpart to the keynsham responders (timer, irq, uart). A bounded timeout guarantees the initiator never hangs on a responder that does not answer.

## Interface
- TIMEOUT, 255: maximum cycles bus_access is held without ack/error before abort; legal range 1..65535.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  client command present.
- cmd_ready  output  1  initiator can accept a command (high only in IDLE).
- cmd_wr  input  1  1 = write, 0 = read.
- cmd_addr  input  32  word-aligned bus address; bits [1:0] ignored, driven as 0.
- cmd_wdata  input  32  write data.
- cmd_bytesel  input  4  write byte enables.
- rsp_valid  output  1  response present; held until rsp_ready.
- rsp_ready  input  1  client accepts response.
- rsp_rdata  output  32  read data (0 for writes and errored accesses).
- rsp_error  output  1  responder signalled bus_error, or timeout.
- rsp_timeout  output  1  access aborted by timeout (implies rsp_error).
- bus_access  output  1  access in progress.
- bus_addr  output  32  access address.
- bus_wr_en  output  1  write strobe, valid while bus_access.
- bus_wr_val  output  32  write data (0 on reads).
- bus_bytesel  output  4  cmd_bytesel on writes, 4'b1111 on reads.
- bus_ack  input  1  responder completion.
- bus_error  input  1  responder error completion.
- bus_data  input  32  responder read data, valid with bus_ack.

## Operation
- States: IDLE, BUS, RESP. Reset state IDLE.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_wr/addr/wdata/bytesel into registers, clear timeout counter, go BUS. bus_ack/bus_error in IDLE ignored.
- BUS: bus_access=1, bus_* driven from latched registers, held stable for the whole state. Counter increments each BUS cycle.
  - bus_error=1: go RESP, rsp_error=1, rsp_timeout=0, rsp_rdata=0 (error wins over simultaneous ack).
  - bus_ack=1 (no error): go RESP, rsp_error=0, rsp_rdata=bus_data for reads, 0 for writes.
  - Neither, counter reaches TIMEOUT-1: go RESP, rsp_error=1, rsp_timeout=1, rsp_rdata=0. Ack/error in that same cycle takes priority over timeout.
- RESP: bus_access=0, rsp_valid=1, response fields stable. On rsp_ready go IDLE. The mandatory RESP cycle guarantees ≥1 idle bus cycle between accesses, since responders ack every cycle access is seen.
- Counter width: 16 bits; never wraps (saturation impossible, exit at TIMEOUT-1).
- Reset (rst_n low, any state, mid-access included): immediately state IDLE, all outputs to reset values; in-flight access abandoned, no response produced.

## Timing
- Reset values: cmd_ready=1 (after reset release; 0 while rst_n low is not required — cmd_ready is combinational from state, so 1), rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, bus_access=0, bus_addr=0, bus_wr_en=0, bus_wr_val=0, bus_bytesel=0.
- All bus_* and rsp_* outputs registered or decoded from state only; no combinational input-to-output path.
- Command accepted at edge E0 → bus_access high cycle after E0.
- Responder with registered ack (ack one cycle after access seen): ack sampled at edge E2 → rsp_valid high from E2; minimum command-to-response latency 2 cycles, command-to-next-accept 3 cycles when rsp_ready held high.
- Timeout: bus_access high exactly TIMEOUT cycles, rsp_valid asserts following edge.
- cmd_ready low from edge accepting the command until the edge where rsp_valid&rsp_ready.

## Test plan
- Write 0x00000003 to timer control (offs 0x8), responder acks next cycle → bus_access high 2 cycles' window, bus_wr_en=1, bus_bytesel=cmd value, rsp_valid after 2 cycles, rsp_error=0, rsp_rdata=0.
- Read timer reload after writing 0x00000010 → rsp_rdata=0x00000010, bus_bytesel=4'hF, bus_wr_val=0.
- No responder (ack never), TIMEOUT=8 → bus_access high exactly 8 cycles, rsp_error=1, rsp_timeout=1, rsp_rdata=0.
- bus_ack and bus_error both asserted with bus_data=0xdeadbeef → rsp_error=1, rsp_timeout=0, rsp_rdata=0; ack on timeout cycle → rsp_timeout=0.
- rsp_ready held low 5 cycles → rsp_valid and fields stable, cmd_ready=0, bus_access=0, new cmd_valid not accepted; back-to-back commands show ≥1 cycle bus_access low between accesses.
- rst_n pulsed low mid-BUS → bus_access drops asynchronously, no rsp_valid, next command after release completes normally.

Source files
------------

// File: rtl/keynsham_bus_initiator.sv
// Single-outstanding initiator for the keynsham peripheral bus: one client command at a time, one bus access, one response.
// Latency: bus_access_o rises the cycle after command accept; rsp_valid_o rises on the edge that samples ack/error/timeout.
// Backpressure: cmd_ready_o is high only in IDLE; the response is held until rsp_ready_i, blocking new commands.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o       client command handshake; cmd_wr_i, cmd_addr_i, cmd_wdata_i, cmd_bytesel_i
//   rsp_valid_o/rsp_ready_i       client response handshake; rsp_rdata_o, rsp_error_o, rsp_timeout_o
//   bus_access_o ... bus_bytesel_o   peripheral bus request, all registered or decoded from state
//   bus_ack_i, bus_error_i, bus_data_i   responder completion
module keynsham_bus_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_wr_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_bytesel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o,
    output logic        rsp_timeout_o,
    output logic        bus_access_o,
    output logic [31:0] bus_addr_o,
    output logic        bus_wr_en_o,
    output logic [31:0] bus_wr_val_o,
    output logic [3:0]  bus_bytesel_o,
    input  logic        bus_ack_i,
    input  logic        bus_error_i,
    input  logic [31:0] bus_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Last counter value before the access is abandoned; bus_access_o is
    // therefore high for exactly TIMEOUT cycles when nobody answers.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  bytesel_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic        timeout_q;

    // Address bits [1:0] are deliberately dropped (word-aligned bus).
    logic unused_addr_lo;
    assign unused_addr_lo = ^cmd_addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bytesel_q <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // bus_ack_i / bus_error_i are ignored here.
                    if (cmd_valid_i) begin
                        state_q   <= ST_BUS;
                        wr_q      <= cmd_wr_i;
                        addr_q    <= {cmd_addr_i[31:2], 2'b00};
                        wdata_q   <= cmd_wr_i ? cmd_wdata_i : 32'h0;
                        bytesel_q <= cmd_wr_i ? cmd_bytesel_i : 4'hF;
                        cnt_q     <= '0;
                    end
                end
                ST_BUS: begin
                    cnt_q <= cnt_q + 16'd1;
                    // Priority: error over ack, both over timeout.
                    if (bus_error_i) begin
                        state_q   <= ST_RESP;
                        rdata_q   <= '0;
                        error_q   <= 1'b1;
                        timeout_q <= 1'b0;
                    end else if (bus_ack_i) begin
                        state_q   <= ST_RESP;
                        rdata_q   <= wr_q ? 32'h0 : bus_data_i;
                        error_q   <= 1'b0;
                        timeout_q <= 1'b0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q   <= ST_RESP;
                        rdata_q   <= '0;
                        error_q   <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // This cycle also guarantees an idle bus cycle between accesses.
                    if (rsp_ready_i) begin
                        state_q   <= ST_IDLE;
                        rdata_q   <= '0;
                        error_q   <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_error_o   = error_q;
    assign rsp_timeout_o = timeout_q;

    assign bus_access_o  = (state_q == ST_BUS);
    assign bus_addr_o    = addr_q;
    assign bus_wr_en_o   = wr_q && (state_q == ST_BUS);
    assign bus_wr_val_o  = wdata_q;
    assign bus_bytesel_o = bytesel_q;

endmodule

// File: tb/tb_keynsham_bus_initiator.sv
module tb_keynsham_bus_initiator;

    localparam int T = 8;

    typedef enum int {M_ACK, M_ERR, M_BOTH, M_NONE} mode_e;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_bytesel;
    logic        rsp_ready;
    logic        bus_ack, bus_error;
    logic [31:0] bus_data;
    logic        cmd_ready_o, rsp_valid_o, rsp_error_o, rsp_timeout_o;
    logic [31:0] rsp_rdata_o, bus_addr_o, bus_wr_val_o;
    logic        bus_access_o, bus_wr_en_o;
    logic [3:0]  bus_bytesel_o;

    always #5 clk = ~clk;

    keynsham_bus_initiator #(.TIMEOUT(T)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_bytesel_i(cmd_bytesel),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
        .rsp_error_o(rsp_error_o), .rsp_timeout_o(rsp_timeout_o),
        .bus_access_o(bus_access_o), .bus_addr_o(bus_addr_o), .bus_wr_en_o(bus_wr_en_o),
        .bus_wr_val_o(bus_wr_val_o), .bus_bytesel_o(bus_bytesel_o),
        .bus_ack_i(bus_ack), .bus_error_i(bus_error), .bus_data_i(bus_data)
    );

    int nvec = 0;
    int nfail = 0;

    exp_t        exp_q[$];
    logic [31:0] ref_mem[logic [31:0]];   // reference model of peripheral contents
    logic [31:0] resp_mem[logic [31:0]];  // what the responder actually stores

    // Current access as seen by the responder / expected bus fields
    mode_e       cfg_mode = M_NONE;
    int          cfg_delay = 0;
    logic [31:0] exp_addr = '0, exp_wval = '0;
    logic        exp_wr = 1'b0;
    logic [3:0]  exp_bsel = '0;
    int          force_hold = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Called at a falling edge. Raises cmd_valid, waits for the initiator to
    // be idle, then records what the access and its response must look like.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input mode_e m, input int d);
        exp_t        e;
        int          guard;
        logic [31:0] wa, old;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_bytesel = be;
        guard = 0;
        while (!cmd_ready_o && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready_o) begin
            check("cmd_accept_wait", 32'(cmd_ready_o), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        wa = {addr[31:2], 2'b00};
        cfg_mode = m; cfg_delay = d;
        exp_addr = wa; exp_wr = wr; exp_wval = wr ? wdata : 32'h0; exp_bsel = wr ? be : 4'hF;
        if (m == M_NONE || d > T) begin
            e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1; e.cycles = T;
        end else if (m != M_ACK) begin
            e.rdata = '0; e.err = 1'b1; e.tmo = 1'b0; e.cycles = d;
        end else begin
            old = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
            e.rdata = wr ? 32'h0 : old;
            e.err = 1'b0; e.tmo = 1'b0; e.cycles = d;
            if (wr) ref_mem[wa] = merge(old, wdata, be);
        end
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wr = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_bytesel = 4'($urandom);
    endtask

    // Responder: answers after cfg_delay access cycles, checks bus fields each
    // access cycle, and drives junk on ack/error/data whenever no access is up.
    initial begin : responder
        int acc;
        logic [31:0] rd;
        bus_ack = 1'b0; bus_error = 1'b0; bus_data = '0; acc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc = 0; bus_ack = 1'b0; bus_error = 1'b0;
            end else if (bus_access_o) begin
                acc++;
                check("bus_addr", bus_addr_o, exp_addr);
                check("bus_wr_en", 32'(bus_wr_en_o), 32'(exp_wr));
                check("bus_wr_val", bus_wr_val_o, exp_wval);
                check("bus_bytesel", 32'(bus_bytesel_o), 32'(exp_bsel));
                if (cfg_mode != M_NONE && acc == cfg_delay) begin
                    bus_ack   = (cfg_mode == M_ACK || cfg_mode == M_BOTH);
                    bus_error = (cfg_mode != M_ACK);
                    if (cfg_mode == M_BOTH) begin
                        bus_data = 32'hdeadbeef;
                    end else if (cfg_mode == M_ACK) begin
                        rd = resp_mem.exists(bus_addr_o) ? resp_mem[bus_addr_o] : 32'h0;
                        if (bus_wr_en_o) begin
                            resp_mem[bus_addr_o] = merge(rd, bus_wr_val_o, bus_bytesel_o);
                            bus_data = $urandom;
                        end else begin
                            bus_data = rd;
                        end
                    end else begin
                        bus_data = $urandom;
                    end
                end else begin
                    bus_ack = 1'b0; bus_error = 1'b0; bus_data = $urandom;
                end
            end else begin
                acc = 0;
                bus_ack = 1'($urandom); bus_error = 1'($urandom); bus_data = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on each new response, checks field
    // stability while the client stalls, and drives rsp_ready.
    initial begin : monitor
        int   accn, hold;
        logic active;
        exp_t e;
        logic [31:0] s_rdata;
        logic s_err, s_tmo;
        rsp_ready = 1'b0; accn = 0; hold = 0; active = 1'b0;
        s_rdata = '0; s_err = 1'b0; s_tmo = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0; accn = 0; rsp_ready = 1'b0;
            end else begin
                if (bus_access_o) accn++;
                if (rsp_valid_o) begin
                    check("rsp_bus_idle", 32'(bus_access_o), 32'd0);
                    check("rsp_cmd_ready", 32'(cmd_ready_o), 32'd0);
                    if (!active) begin
                        if (exp_q.size() == 0) begin
                            nvec++; nfail++;
                            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_rdata", rsp_rdata_o, e.rdata);
                            check("rsp_error", 32'(rsp_error_o), 32'(e.err));
                            check("rsp_timeout", 32'(rsp_timeout_o), 32'(e.tmo));
                            check("access_cycles", 32'(accn), 32'(e.cycles));
                        end
                        s_rdata = rsp_rdata_o; s_err = rsp_error_o; s_tmo = rsp_timeout_o;
                        active = 1'b1; accn = 0;
                        hold = (force_hold > 0) ? force_hold : int'($urandom_range(0, 2));
                        force_hold = 0;
                    end else begin
                        check("hold_rdata", rsp_rdata_o, s_rdata);
                        check("hold_error", 32'(rsp_error_o), 32'(s_err));
                        check("hold_timeout", 32'(rsp_timeout_o), 32'(s_tmo));
                    end
                    if (hold > 0) begin
                        rsp_ready = 1'b0; hold--;
                    end else begin
                        rsp_ready = 1'b1; active = 1'b0;
                    end
                end else begin
                    rsp_ready = 1'($urandom);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of run expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
        check({tag, "_rsp_error"}, 32'(rsp_error_o), 32'd0);
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout_o), 32'd0);
        check({tag, "_bus_access"}, 32'(bus_access_o), 32'd0);
        check({tag, "_bus_addr"}, bus_addr_o, 32'd0);
        check({tag, "_bus_wr_en"}, 32'(bus_wr_en_o), 32'd0);
        check({tag, "_bus_wr_val"}, bus_wr_val_o, 32'd0);
        check({tag, "_bus_bytesel"}, 32'(bus_bytesel_o), 32'd0);
    endtask

    initial begin : stimulus
        int guard;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_bytesel = '0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: timer control write, registered-ack responder
        issue(1'b1, 32'h0000_0008, 32'h0000_0003, 4'hF, M_ACK, 2);
        // Reload write then read back
        issue(1'b1, 32'h0000_0004, 32'h0000_0010, 4'hF, M_ACK, 2);
        issue(1'b0, 32'h0000_0004, 32'h1234_5678, 4'h3, M_ACK, 2);
        // Silent responder: timeout after exactly T access cycles
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, M_NONE, 0);
        // Ack and error together
        issue(1'b0, 32'h0000_0008, 32'h0, 4'h0, M_BOTH, 2);
        // Ack / error on the timeout cycle win; one cycle later loses
        issue(1'b0, 32'h0000_0008, 32'h0, 4'h0, M_ACK, T);
        issue(1'b1, 32'h0000_000b, 32'hAABB_CCDD, 4'h5, M_ERR, T);
        issue(1'b0, 32'h0000_0008, 32'h0, 4'h0, M_ACK, T + 1);
        // Combinational-ack responder, partial-byte write then read
        issue(1'b1, 32'h0000_000a, 32'hAABB_CCDD, 4'h6, M_ACK, 1);
        issue(1'b0, 32'h0000_0009, 32'h0, 4'h0, M_ACK, 1);
        // Client stalls the response for 5 cycles while a new command waits
        force_hold = 5;
        issue(1'b0, 32'h0000_0004, 32'h0, 4'h0, M_ACK, 3);
        issue(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'hF, M_ACK, 2);

        // Reset in the middle of an access
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, M_NONE, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, M_ACK, 2);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int    r, d;
            mode_e m;
            r = int'($urandom_range(0, 9));
            d = int'($urandom_range(1, 10));
            m = (r <= 5 || r == 9) ? M_ACK : (r == 6) ? M_ERR : (r == 7) ? M_BOTH : M_NONE;
            issue(1'($urandom), {26'h0, 4'($urandom), 2'($urandom)}, $urandom, 4'($urandom), m, d);
            if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end

        guard = 0;
        while ((exp_q.size() != 0 || !cmd_ready_o) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(cmd_ready_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
